// File: rtl/gpio_board_bridge_pkg.sv
// gpio_board_bridge_pkg: shared constants and per-channel debounce state for the GPIO board bridge.
package gpio_board_bridge_pkg;
  localparam int PWM_W = 8;
  localparam int DEBOUNCE_DEFAULT = 100000;
  localparam int DB_CNT_W = 32;
  typedef struct packed {
    logic q;
    logic [DB_CNT_W-1:0] c;
  } db_state_t;
endpackage

// File: rtl/gpio_board_bridge_if.sv
// gpio_board_bridge_if: board/SoC-facing GPIO signals; io_brightness exists only with GPIO_PWM_EN.
interface gpio_board_bridge_if
  import gpio_board_bridge_pkg::*;
#(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] io_sw;
  logic [WIDTH-1:0] io_led;
  logic [WIDTH-1:0] io_gpio_read;
  logic [WIDTH-1:0] io_gpio_write;
  logic [WIDTH-1:0] io_gpio_writeEnable;
  logic [WIDTH-1:0] io_changeClear;
  logic [WIDTH-1:0] io_changeFlags;
  logic             io_irq;
`ifdef GPIO_PWM_EN
  logic [PWM_W-1:0] io_brightness;
`endif
  modport master (
`ifdef GPIO_PWM_EN
    output io_brightness,
`endif
    output io_sw, io_gpio_write, io_gpio_writeEnable, io_changeClear,
    input  io_led, io_gpio_read, io_changeFlags, io_irq
  );
  modport slave (
`ifdef GPIO_PWM_EN
    input  io_brightness,
`endif
    input  io_sw, io_gpio_write, io_gpio_writeEnable, io_changeClear,
    output io_led, io_gpio_read, io_changeFlags, io_irq
  );
endinterface

// File: rtl/gpio_debounce_ch.sv
// gpio_debounce_ch: one channel's synchroniser, debouncer and change-event pulse.
module gpio_debounce_ch
  import gpio_board_bridge_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_i,
  output logic q_o,
  output logic chg_o
);
  localparam logic [DB_CNT_W-1:0] LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [SYNC_STAGES-1:0] sync_q;
  db_state_t st_q, st_d;
  logic s;
  assign s = sync_q[SYNC_STAGES-1];
  assign chg_o = (s != st_q.q) && (st_q.c == LAST);
  assign q_o = st_q.q;
  // Counter is physically CNT_W bits; the cast lets the upper struct bits fold to zero.
  always_comb begin
    st_d.q = chg_o ? s : st_q.q;
    st_d.c = (s == st_q.q || chg_o) ? '0 : DB_CNT_W'(CNT_W'(st_q.c + 1'b1));
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      st_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sw_i};
      st_q <= st_d;
    end
  end
endmodule

// File: rtl/gpio_board_bridge.sv
// gpio_board_bridge: debounced switch inputs with sticky change flags/IRQ and registered LED drive.
// Optional global PWM dimming of the LEDs when GPIO_PWM_EN is defined.
module gpio_board_bridge
  import gpio_board_bridge_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input logic io_mainClk,
  input logic io_mainResetn,
  gpio_board_bridge_if.slave bus
);
  logic [WIDTH-1:0] read, chg, flags_q, flags_d, led_q, led_d;
  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    gpio_debounce_ch #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W(CNT_W)
    ) u_ch (
      .clk(io_mainClk),
      .rst_n(io_mainResetn),
      .sw_i(bus.io_sw[g]),
      .q_o(read[g]),
      .chg_o(chg[g])
    );
  end
  // A change event in the same cycle as a clear keeps the flag set.
  assign flags_d = (flags_q & ~bus.io_changeClear) | chg;
`ifdef GPIO_PWM_EN
  logic [PWM_W-1:0] p_q;
  assign led_d = bus.io_gpio_write & bus.io_gpio_writeEnable & {WIDTH{p_q < bus.io_brightness}};
`else
  assign led_d = bus.io_gpio_write & bus.io_gpio_writeEnable;
`endif
  always_ff @(posedge io_mainClk) begin
    if (!io_mainResetn) begin
      flags_q <= '0;
      led_q <= '0;
`ifdef GPIO_PWM_EN
      p_q <= '0;
`endif
    end else begin
      flags_q <= flags_d;
      led_q <= led_d;
`ifdef GPIO_PWM_EN
      p_q <= p_q + 1'b1;
`endif
    end
  end
  assign bus.io_gpio_read = read;
  assign bus.io_changeFlags = flags_q;
  assign bus.io_irq = |flags_q;
  assign bus.io_led = led_q;
endmodule

// File: tb/tb_gpio_board_bridge.sv
// tb_gpio_board_bridge: directed checks of debounce latency, glitch rejection, flags, LEDs and reset.
module tb_gpio_board_bridge;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  gpio_board_bridge_if #(.WIDTH(4)) bus ();
  gpio_board_bridge #(
    .WIDTH(4),
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .io_mainClk(clk),
    .io_mainResetn(rstn),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    bus.io_sw = 4'h0;
    bus.io_gpio_write = 4'h0;
    bus.io_gpio_writeEnable = 4'h0;
    bus.io_changeClear = 4'h0;
`ifdef GPIO_PWM_EN
    bus.io_brightness = 8'd0;
`endif
    cyc(3);
    chk("rst_read", 32'(bus.io_gpio_read), 32'h0);
    chk("rst_flags", 32'(bus.io_changeFlags), 32'h0);
    chk("rst_irq", 32'(bus.io_irq), 32'h0);
    chk("rst_led", 32'(bus.io_led), 32'h0);
    rstn = 1'b1;
    cyc(2);
    bus.io_sw = 4'h1;
    cyc(5);
    chk("lat_read_5", 32'(bus.io_gpio_read), 32'h0);
    chk("lat_flags_5", 32'(bus.io_changeFlags), 32'h0);
    cyc(1);
    chk("lat_read_6", 32'(bus.io_gpio_read), 32'h1);
    chk("lat_flags_6", 32'(bus.io_changeFlags), 32'h1);
    chk("lat_irq_6", 32'(bus.io_irq), 32'h1);
    bus.io_sw = 4'h3;
    cyc(3);
    bus.io_sw = 4'h1;
    cyc(3);
    chk("glitch_read_mid", 32'(bus.io_gpio_read), 32'h1);
    cyc(8);
    chk("glitch_read", 32'(bus.io_gpio_read), 32'h1);
    chk("glitch_flags", 32'(bus.io_changeFlags), 32'h1);
    bus.io_sw = 4'h0;
    cyc(5);
    chk("fall_read_5", 32'(bus.io_gpio_read), 32'h1);
    bus.io_changeClear = 4'h1;
    cyc(1);
    bus.io_changeClear = 4'h0;
    chk("fall_read_6", 32'(bus.io_gpio_read), 32'h0);
    chk("set_wins", 32'(bus.io_changeFlags), 32'h1);
    cyc(1);
    bus.io_changeClear = 4'h1;
    cyc(1);
    bus.io_changeClear = 4'h0;
    chk("clear_flags", 32'(bus.io_changeFlags), 32'h0);
    chk("clear_irq", 32'(bus.io_irq), 32'h0);
    bus.io_changeClear = 4'hF;
    cyc(1);
    bus.io_changeClear = 4'h0;
    chk("clear_idle", 32'(bus.io_changeFlags), 32'h0);
`ifndef GPIO_PWM_EN
    bus.io_gpio_write = 4'hF;
    bus.io_gpio_writeEnable = 4'h5;
    chk("led_pre", 32'(bus.io_led), 32'h0);
    cyc(1);
    chk("led_we5", 32'(bus.io_led), 32'h5);
    bus.io_gpio_writeEnable = 4'h0;
    cyc(1);
    chk("led_we0", 32'(bus.io_led), 32'h0);
    bus.io_gpio_write = 4'hA;
    bus.io_gpio_writeEnable = 4'hF;
    cyc(1);
    chk("led_wA", 32'(bus.io_led), 32'hA);
`endif
    bus.io_sw = 4'h8;
    cyc(6);
    chk("ch3_read", 32'(bus.io_gpio_read), 32'h8);
    chk("ch3_flags", 32'(bus.io_changeFlags), 32'h8);
    bus.io_sw = 4'hC;
    cyc(4);
    rstn = 1'b0;
    cyc(1);
    chk("mid_rst_read", 32'(bus.io_gpio_read), 32'h0);
    chk("mid_rst_flags", 32'(bus.io_changeFlags), 32'h0);
    chk("mid_rst_irq", 32'(bus.io_irq), 32'h0);
    chk("mid_rst_led", 32'(bus.io_led), 32'h0);
    rstn = 1'b1;
    cyc(5);
    chk("post_rst_read_5", 32'(bus.io_gpio_read), 32'h0);
    chk("post_rst_flags_5", 32'(bus.io_changeFlags), 32'h0);
    cyc(1);
    chk("post_rst_read_6", 32'(bus.io_gpio_read), 32'hC);
    chk("post_rst_flags_6", 32'(bus.io_changeFlags), 32'hC);
`ifdef GPIO_PWM_EN
    begin
      int on;
      bus.io_gpio_write = 4'hF;
      bus.io_gpio_writeEnable = 4'hF;
      bus.io_brightness = 8'd64;
      cyc(2);
      on = 0;
      for (int i = 0; i < 256; i++) begin
        cyc(1);
        if (bus.io_led == 4'hF) on++;
      end
      chk("pwm_64", 32'(on), 32'd64);
      bus.io_brightness = 8'd0;
      cyc(2);
      on = 0;
      for (int i = 0; i < 256; i++) begin
        cyc(1);
        if (bus.io_led != 4'h0) on++;
      end
      chk("pwm_0", 32'(on), 32'd0);
    end
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
